axi4_lite_slave_regs: RTL and testbench

AXI4_LITE_SLAVE_REGS -- requirements
Module: axi4_lite_slave_regs

---
 rtl/axi4_lite_pkg.sv | 25 ++
 rtl/axi4_lite_strb_merge.sv | 21 ++
 rtl/axi4_lite_slave_regs.sv | 198 +++++++++++++++++++
 tb/tb_axi4_lite_slave_regs.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite response codes and FSM state encodings for the register slave.
// Latency: none (type and constant definitions only).
// Backpressure: not applicable.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_COMMIT = 2'd1,
    W_RESP   = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_e;

  // Map an address range check onto the AXI response code.
  function automatic logic [1:0] resp_for(input logic in_range);
    return in_range ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/axi4_lite_strb_merge.sv
// Byte-lane merge: each lane takes the new write data where its strobe is set, else keeps the old word.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module axi4_lite_strb_merge #(
  parameter int DW = 32
) (
  input  logic [DW-1:0]   old_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [DW/8-1:0] strb_i,
  output logic [DW-1:0]   merged_o
);

  // Lane-by-lane select between the stored word and the incoming data.
  always_comb begin
    merged_o = old_i;
    for (int b = 0; b < DW / 8; b++) begin
      if (strb_i[b]) merged_o[b*8 +: 8] = wdata_i[b*8 +: 8];
    end
  end

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave exposing NREGS 32-bit read/write registers, with a commit strobe for side effects.
// Latency: read 1 cycle AR handshake -> RVALID; write 2 cycles last AW/W handshake -> BVALID.
// Backpressure: one write and one read outstanding; READY drops until BREADY/RREADY accept the response.
module axi4_lite_slave_regs
  import axi4_lite_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 8,
  parameter int NREGS = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [AW-1:0]              S_AXI_AWADDR,
  input  logic                       S_AXI_AWVALID,
  output logic                       S_AXI_AWREADY,
  input  logic [DW-1:0]              S_AXI_WDATA,
  input  logic [DW/8-1:0]            S_AXI_WSTRB,
  input  logic                       S_AXI_WVALID,
  output logic                       S_AXI_WREADY,
  output logic [1:0]                 S_AXI_BRESP,
  output logic                       S_AXI_BVALID,
  input  logic                       S_AXI_BREADY,
  input  logic [AW-1:0]              S_AXI_ARADDR,
  input  logic                       S_AXI_ARVALID,
  output logic                       S_AXI_ARREADY,
  output logic [DW-1:0]              S_AXI_RDATA,
  output logic [1:0]                 S_AXI_RRESP,
  output logic                       S_AXI_RVALID,
  input  logic                       S_AXI_RREADY,
  output logic [NREGS*DW-1:0]        REGS_OUT,
  output logic                       WR_STROBE,
  output logic [$clog2(NREGS)-1:0]   WR_INDEX
);

  localparam int IW = $clog2(NREGS);
  // One past the last valid byte address; the extra bit keeps the compare
  // correct when the register window fills the whole address space.
  localparam logic [AW:0] LIMIT = (AW+1)'(NREGS * 4);

  logic [NREGS-1:0][DW-1:0] regs_q;

  // Write channel state
  wr_state_e         wr_state_q;
  logic [AW-1:0]     awaddr_q;
  logic [DW-1:0]     wdata_q;
  logic [DW/8-1:0]   wstrb_q;
  logic              aw_got_q, w_got_q;
  logic              awready_q, wready_q;
  logic              bvalid_q;
  logic [1:0]        bresp_q;
  logic              wr_strobe_q;
  logic [IW-1:0]     wr_index_q;

  // Read channel state
  rd_state_e         rd_state_q;
  logic              arready_q;
  logic              rvalid_q;
  logic [1:0]        rresp_q;
  logic [DW-1:0]     rdata_q;

  logic              aw_hs, w_hs, ar_hs;
  logic              aw_got_d, w_got_d;
  logic [AW-1:0]     awaddr_d;
  logic              awaddr_d_in_range;
  logic              wr_in_range;
  logic              rd_in_range;
  logic [IW-1:0]     rd_idx;
  logic [DW-1:0]     merged;

  assign aw_hs = S_AXI_AWVALID && awready_q;
  assign w_hs  = S_AXI_WVALID && wready_q;
  assign ar_hs = S_AXI_ARVALID && arready_q;

  assign aw_got_d = aw_got_q | aw_hs;
  assign w_got_d  = w_got_q | w_hs;

  // The address may arrive in the same cycle the FSM leaves idle, so decode from the bypassed value.
  assign awaddr_d          = aw_hs ? S_AXI_AWADDR : awaddr_q;
  assign awaddr_d_in_range = ({1'b0, awaddr_d} < LIMIT);
  assign wr_in_range       = ({1'b0, awaddr_q} < LIMIT);

  assign rd_in_range = ({1'b0, S_AXI_ARADDR} < LIMIT);
  assign rd_idx      = S_AXI_ARADDR[IW+1:2];

  axi4_lite_strb_merge #(.DW(DW)) u_strb_merge (
    .old_i    (regs_q[wr_index_q]),
    .wdata_i  (wdata_q),
    .strb_i   (wstrb_q),
    .merged_o (merged)
  );

  // Write FSM: capture AW and W independently, commit for one cycle, then hold the response until BREADY.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_state_q  <= W_IDLE;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_got_q    <= 1'b0;
      w_got_q     <= 1'b0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      wr_strobe_q <= 1'b0;
      wr_index_q  <= '0;
    end else begin
      wr_strobe_q <= 1'b0;
      case (wr_state_q)
        W_IDLE: begin
          if (aw_hs) awaddr_q <= S_AXI_AWADDR;
          if (w_hs) begin
            wdata_q <= S_AXI_WDATA;
            wstrb_q <= S_AXI_WSTRB;
          end
          if (aw_got_d && w_got_d) begin
            wr_state_q  <= W_COMMIT;
            aw_got_q    <= 1'b0;
            w_got_q     <= 1'b0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            wr_strobe_q <= awaddr_d_in_range;
            wr_index_q  <= awaddr_d[IW+1:2];
          end else begin
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            awready_q <= !aw_got_d;
            wready_q  <= !w_got_d;
          end
        end
        W_COMMIT: begin
          wr_state_q <= W_RESP;
          bvalid_q   <= 1'b1;
          bresp_q    <= resp_for(wr_in_range);
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            wr_state_q <= W_IDLE;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  // Register file: the commit edge updates the strobed lanes; a read sampling the same edge sees the old word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      regs_q <= '0;
    end else if (wr_state_q == W_COMMIT && wr_strobe_q) begin
      regs_q[wr_index_q] <= merged;
    end
  end

  // Read FSM: register data and response on the AR handshake, hold them until RREADY.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else if (rd_state_q == R_IDLE) begin
      if (ar_hs) begin
        rd_state_q <= R_RESP;
        arready_q  <= 1'b0;
        rvalid_q   <= 1'b1;
        rresp_q    <= resp_for(rd_in_range);
        rdata_q    <= rd_in_range ? regs_q[rd_idx] : '0;
      end else begin
        arready_q  <= 1'b1;
      end
    end else begin
      if (S_AXI_RREADY) begin
        rd_state_q <= R_IDLE;
        arready_q  <= 1'b1;
        rvalid_q   <= 1'b0;
      end
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign REGS_OUT      = regs_q;
  assign WR_STROBE     = wr_strobe_q;
  assign WR_INDEX      = wr_index_q;

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed bench for the AXI4-Lite register slave with hand-computed expectations.
// Latency: checks 1-cycle read and 2-cycle write response timing.
// Backpressure: exercises held BREADY and reset in the middle of a write.
module tb_axi4_lite_slave_regs;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int NREGS = 16;

  logic                  clk = 1'b0;
  logic                  resetn = 1'b0;
  logic [AW-1:0]         S_AXI_AWADDR = '0;
  logic                  S_AXI_AWVALID = 1'b0;
  logic                  S_AXI_AWREADY;
  logic [DW-1:0]         S_AXI_WDATA = '0;
  logic [DW/8-1:0]       S_AXI_WSTRB = '0;
  logic                  S_AXI_WVALID = 1'b0;
  logic                  S_AXI_WREADY;
  logic [1:0]            S_AXI_BRESP;
  logic                  S_AXI_BVALID;
  logic                  S_AXI_BREADY = 1'b0;
  logic [AW-1:0]         S_AXI_ARADDR = '0;
  logic                  S_AXI_ARVALID = 1'b0;
  logic                  S_AXI_ARREADY;
  logic [DW-1:0]         S_AXI_RDATA;
  logic [1:0]            S_AXI_RRESP;
  logic                  S_AXI_RVALID;
  logic                  S_AXI_RREADY = 1'b0;
  logic [NREGS*DW-1:0]   REGS_OUT;
  logic                  WR_STROBE;
  logic [$clog2(NREGS)-1:0] WR_INDEX;

  int n_chk = 0;
  int n_pass = 0;
  int strobe_cnt = 0;
  logic [31:0] model [NREGS];

  always #5 clk = ~clk;

  axi4_lite_slave_regs #(.DW(DW), .AW(AW), .NREGS(NREGS)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .REGS_OUT      (REGS_OUT),
    .WR_STROBE     (WR_STROBE),
    .WR_INDEX      (WR_INDEX)
  );

  // Count commit pulses seen on rising edges.
  always @(posedge clk) if (WR_STROBE) strobe_cnt <= strobe_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < NREGS; i++)
      chk($sformatf("%s_r%0d", tag, i), REGS_OUT[i*32 +: 32], model[i]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    logic aw_done, w_done, aw_hs, w_hs;
    int n;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      step(); n++;
      if (aw_hs) begin aw_done = 1'b1; S_AXI_AWVALID = 1'b0; end
      if (w_hs)  begin w_done = 1'b1;  S_AXI_WVALID = 1'b0; end
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    n = 0;
    while (!S_AXI_BVALID && n < 20) begin step(); n++; end
    chk("wr_bvalid", S_AXI_BVALID, 1);
    resp = S_AXI_BRESP;
    step();
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    n = 0;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    while (!S_AXI_ARREADY && n < 20) begin step(); n++; end
    step();
    S_AXI_ARVALID = 1'b0;
    chk("rd_latency_rvalid", S_AXI_RVALID, 1);
    d = S_AXI_RDATA;
    r = S_AXI_RRESP;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    logic [1:0]  rr;
    int s0;
    int bad;

    for (int i = 0; i < NREGS; i++) model[i] = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", S_AXI_AWREADY, 0);
    chk("rst_wready",  S_AXI_WREADY, 0);
    chk("rst_arready", S_AXI_ARREADY, 0);
    chk("rst_bvalid",  S_AXI_BVALID, 0);
    chk("rst_rvalid",  S_AXI_RVALID, 0);
    chk("rst_strobe",  WR_STROBE, 0);
    chk("rst_bresp",   S_AXI_BRESP, 0);
    chk("rst_rresp",   S_AXI_RRESP, 0);
    chk("rst_rdata",   S_AXI_RDATA, 0);
    chk_regs("rst");
    resetn = 1'b1;
    step();
    chk("post_rst_awready", S_AXI_AWREADY, 1);
    chk("post_rst_wready",  S_AXI_WREADY, 1);
    chk("post_rst_arready", S_AXI_ARREADY, 1);

    // AW and W together to 0x08
    s0 = strobe_cnt;
    S_AXI_AWADDR = 8'h08; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    S_AXI_BREADY = 1'b1;
    step();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    chk("t1_strobe",  WR_STROBE, 1);
    chk("t1_index",   WR_INDEX, 2);
    chk("t1_bvalid_early", S_AXI_BVALID, 0);
    chk("t1_awready_commit", S_AXI_AWREADY, 0);
    step();
    chk("t1_bvalid", S_AXI_BVALID, 1);
    chk("t1_bresp",  S_AXI_BRESP, 2'b00);
    model[2] = 32'hDEADBEEF;
    chk_regs("t1");
    step();
    chk("t1_bvalid_done", S_AXI_BVALID, 0);
    chk("t1_awready_back", S_AXI_AWREADY, 1);
    chk("t1_pulses", strobe_cnt - s0, 1);

    // W three cycles ahead of AW, partial strobe
    do_write(8'h04, 32'hFFFFFFFF, 4'hF, resp);
    chk("t2_pre_resp", resp, 2'b00);
    model[1] = 32'hFFFFFFFF;
    S_AXI_WDATA = 32'h11223344; S_AXI_WSTRB = 4'h5; S_AXI_WVALID = 1'b1;
    step();
    S_AXI_WVALID = 1'b0;
    chk("t2_wready_held", S_AXI_WREADY, 0);
    chk("t2_awready_wait", S_AXI_AWREADY, 1);
    step();
    step();
    S_AXI_AWADDR = 8'h04; S_AXI_AWVALID = 1'b1;
    step();
    S_AXI_AWVALID = 1'b0;
    chk("t2_strobe", WR_STROBE, 1);
    chk("t2_index",  WR_INDEX, 1);
    step();
    chk("t2_bvalid", S_AXI_BVALID, 1);
    chk("t2_bresp",  S_AXI_BRESP, 2'b00);
    model[1] = 32'hFF22FF44;
    chk("t2_r1", REGS_OUT[63:32], 32'hFF22FF44);
    step();

    // Out-of-range write and read
    s0 = strobe_cnt;
    do_write(8'h40, 32'hCAFEF00D, 4'hF, resp);
    chk("t3_bresp", resp, 2'b10);
    chk("t3_pulses", strobe_cnt - s0, 0);
    chk_regs("t3");
    do_read(8'h44, rd, rr);
    chk("t3_rdata_oor", rd, 32'h0);
    chk("t3_rresp_oor", rr, 2'b10);
    do_read(8'h08, rd, rr);
    chk("t3_rdata_r2", rd, 32'hDEADBEEF);
    chk("t3_rresp_r2", rr, 2'b00);

    // BREADY held low for 10 cycles while a read completes
    S_AXI_AWADDR = 8'h0C; S_AXI_WDATA = 32'h1; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    step();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    step();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!(S_AXI_BVALID === 1'b1 && S_AXI_BRESP === 2'b00 &&
            S_AXI_AWREADY === 1'b0 && S_AXI_WREADY === 1'b0)) bad++;
      if (i == 1) begin
        chk("t4_arready", S_AXI_ARREADY, 1);
        S_AXI_ARADDR = 8'h08; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
      end
      if (i == 2) begin
        S_AXI_ARVALID = 1'b0;
        chk("t4_rvalid", S_AXI_RVALID, 1);
        chk("t4_rdata",  S_AXI_RDATA, 32'hDEADBEEF);
      end
      step();
    end
    chk("t4_bhold_bad_cycles", bad, 0);
    chk("t4_rvalid_done", S_AXI_RVALID, 0);
    S_AXI_BREADY = 1'b1;
    step();
    chk("t4_bvalid_done", S_AXI_BVALID, 0);
    model[3] = 32'h1;
    chk("t4_r3", REGS_OUT[127:96], 32'h1);

    // Read in the commit cycle of a write to the same register
    S_AXI_AWADDR = 8'h0C; S_AXI_WDATA = 32'h5; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    step();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    chk("t5_strobe", WR_STROBE, 1);
    chk("t5_arready", S_AXI_ARREADY, 1);
    S_AXI_ARADDR = 8'h0C; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    step();
    S_AXI_ARVALID = 1'b0;
    chk("t5_rvalid", S_AXI_RVALID, 1);
    chk("t5_rdata_old", S_AXI_RDATA, 32'h1);
    chk("t5_bvalid", S_AXI_BVALID, 1);
    step();
    model[3] = 32'h5;
    do_read(8'h0C, rd, rr);
    chk("t5_rdata_new", rd, 32'h5);

    // Reset after AW handshake, before W
    S_AXI_AWADDR = 8'h10; S_AXI_AWVALID = 1'b1;
    step();
    S_AXI_AWVALID = 1'b0;
    chk("t6_awready_captured", S_AXI_AWREADY, 0);
    chk("t6_wready_waiting",   S_AXI_WREADY, 1);
    resetn = 1'b0;
    step();
    chk("t6_rst_awready", S_AXI_AWREADY, 0);
    chk("t6_rst_wready",  S_AXI_WREADY, 0);
    chk("t6_rst_arready", S_AXI_ARREADY, 0);
    chk("t6_rst_bvalid",  S_AXI_BVALID, 0);
    for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
    chk_regs("t6_rst");
    step();
    resetn = 1'b1;
    step();
    chk("t6_awready", S_AXI_AWREADY, 1);
    chk("t6_wready",  S_AXI_WREADY, 1);
    chk("t6_arready", S_AXI_ARREADY, 1);
    chk("t6_bvalid",  S_AXI_BVALID, 0);
    s0 = strobe_cnt;
    S_AXI_WDATA = 32'h12345678; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    step();
    S_AXI_WVALID = 1'b0;
    repeat (4) step();
    chk("t6_no_bvalid", S_AXI_BVALID, 0);
    chk("t6_no_pulse", strobe_cnt - s0, 0);
    chk_regs("t6_post");
    S_AXI_AWADDR = 8'h10; S_AXI_AWVALID = 1'b1;
    step();
    S_AXI_AWVALID = 1'b0;
    chk("t6_strobe", WR_STROBE, 1);
    chk("t6_index",  WR_INDEX, 4);
    step();
    chk("t6_bvalid_late", S_AXI_BVALID, 1);
    model[4] = 32'h12345678;
    chk("t6_r4", REGS_OUT[159:128], 32'h12345678);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
